// File: rtl/dma_engine_if.sv
// Bus bundle shared by the DMA engine and the CPU-side memory bus.
// Signals:
//   bus_req  engine wants the bus
//   bus_gnt  CPU has released the bus
//   address  registered bus address
//   i_data   read data, valid one cycle after its address
//   o_data   write data
//   we       write enable
// Modports: master (the DMA engine), slave (memory / bus arbiter side).
interface dma_engine_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] address;
  logic [7:0]        i_data;
  logic [7:0]        o_data;
  logic              we;

  modport master (
    output bus_req,
    output address,
    output o_data,
    output we,
    input  bus_gnt,
    input  i_data
  );

  modport slave (
    input  bus_req,
    input  address,
    input  o_data,
    input  we,
    output bus_gnt,
    output i_data
  );
endinterface

// File: rtl/dma_engine.sv
// Multi-channel byte-copy DMA master sharing the CPU's 8-bit data bus.
// Each channel holds src/dst/len/mode registers written through a small config
// port; a start bit marks a channel busy, and the engine then copies len bytes
// from src to dst, one byte every four cycles, using fixed-priority arbitration.
// Ports:
//   clock     system clock
//   resetn    synchronous active-low reset
//   locked    clock enable; when low every register holds
//   cfg_we    config write strobe
//   cfg_addr  {channel, reg}: 0/1 src lo/hi, 2/3 dst lo/hi, 4/5 len lo/hi, 6 mode
//   cfg_data  config write data
//   start     per-channel start request (level)
//   bus       master side of the memory bus bundle
//   busy      channel pending or active
//   done      one-cycle pulse when a channel finishes
module dma_engine #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned LEN_W    = 16
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        locked,
  input  logic                        cfg_we,
  input  logic [2+$clog2(CHANNELS):0] cfg_addr,
  input  logic [7:0]                  cfg_data,
  input  logic [CHANNELS-1:0]         start,
  dma_engine_if.master                bus,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS-1:0]         done
);

  localparam int unsigned SelBits = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {StIdle, StReq, StRd, StCap, StWr, StNext} state_e;

  state_e               r_state;
  logic [SelBits-1:0]   r_sel;
  logic                 r_bus_req;
  logic                 r_we;
  logic [7:0]           r_o_data;
  logic [ADDR_W-1:0]    r_address;
  logic [CHANNELS-1:0]  r_busy;
  logic [CHANNELS-1:0]  r_done;

  logic [ADDR_W-1:0]    r_src  [CHANNELS];
  logic [ADDR_W-1:0]    r_dst  [CHANNELS];
  logic [LEN_W-1:0]     r_len  [CHANNELS];
  logic [3:0]           r_mode [CHANNELS];

  logic [31:0]          w_cfg_ch;
  logic [SelBits-1:0]   w_pick;
  logic [ADDR_W-1:0]    w_src_nxt;
  logic [ADDR_W-1:0]    w_dst_nxt;
  logic [LEN_W-1:0]     w_len_nxt;

  // Step encoding: 01 holds, 10 decrements, 00/11 increment; wraps in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0]        m);
    case (m)
      2'b01:   return a;
      2'b10:   return a - ADDR_W'(1);
      default: return a + ADDR_W'(1);
    endcase
  endfunction

  // Replace the low or high byte of a register image; upper bits are kept.
  function automatic logic [31:0] put_byte(input logic [31:0] cur,
                                           input logic        hi,
                                           input logic [7:0]  b);
    logic [31:0] v;
    v = cur;
    if (hi) v[15:8] = b;
    else    v[7:0]  = b;
    return v;
  endfunction

  // Channel field of cfg_addr sits above the 3-bit register index.
  assign w_cfg_ch = 32'(cfg_addr >> 3);

  // Fixed priority: the lowest-index busy channel wins.
  always_comb begin
    w_pick = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (r_busy[i]) w_pick = SelBits'(i);
    end
  end

  assign w_src_nxt = step_addr(r_src[r_sel], r_mode[r_sel][1:0]);
  assign w_dst_nxt = step_addr(r_dst[r_sel], r_mode[r_sel][3:2]);
  assign w_len_nxt = r_len[r_sel] - LEN_W'(1);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_sel     <= '0;
      r_bus_req <= 1'b0;
      r_we      <= 1'b0;
      r_o_data  <= '0;
      r_address <= '0;
      r_busy    <= '0;
      r_done    <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_src[i]  <= '0;
        r_dst[i]  <= '0;
        r_len[i]  <= '0;
        r_mode[i] <= '0;
      end
    end else if (locked) begin
      r_done <= '0;

      // Config and start only touch idle channels, so they never collide with
      // the FSM, which only updates the selected (busy) channel.
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (cfg_we && (w_cfg_ch == i) && !r_busy[i]) begin
          case (cfg_addr[2:0])
            3'd0, 3'd1: r_src[i] <= ADDR_W'(put_byte(32'(r_src[i]), cfg_addr[0], cfg_data));
            3'd2, 3'd3: r_dst[i] <= ADDR_W'(put_byte(32'(r_dst[i]), cfg_addr[0], cfg_data));
            3'd4, 3'd5: r_len[i] <= LEN_W'(put_byte(32'(r_len[i]), cfg_addr[0], cfg_data));
            3'd6:       r_mode[i] <= cfg_data[3:0];
            default:    ;
          endcase
        end
        if (start[i] && !r_busy[i]) begin
          // A zero-length request completes immediately without using the bus.
          if (r_len[i] == '0) r_done[i] <= 1'b1;
          else                r_busy[i] <= 1'b1;
        end
      end

      case (r_state)
        StIdle: begin
          if (|r_busy) begin
            r_sel     <= w_pick;
            r_bus_req <= 1'b1;
            r_state   <= StReq;
          end
        end
        StReq: begin
          if (bus.bus_gnt) begin
            r_address <= r_src[r_sel];
            r_state   <= StRd;
          end
        end
        StRd: begin
          r_state <= StCap;
        end
        StCap: begin
          r_o_data  <= bus.i_data;
          r_address <= r_dst[r_sel];
          r_we      <= 1'b1;
          r_state   <= StWr;
        end
        StWr: begin
          r_we    <= 1'b0;
          r_state <= StNext;
        end
        StNext: begin
          r_src[r_sel] <= w_src_nxt;
          r_dst[r_sel] <= w_dst_nxt;
          r_len[r_sel] <= w_len_nxt;
          if (w_len_nxt == '0) begin
            r_busy[r_sel] <= 1'b0;
            r_done[r_sel] <= 1'b1;
            r_bus_req     <= 1'b0;
            r_state       <= StIdle;
          end else if (bus.bus_gnt) begin
            r_address <= w_src_nxt;
            r_state   <= StRd;
          end else begin
            // Grant withdrawn: keep requesting and resume once it returns.
            r_state <= StReq;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.bus_req = r_bus_req;
  assign bus.address = r_address;
  assign bus.o_data  = r_o_data;
  assign bus.we      = r_we;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
